mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   Iterative RV32M multiply/divide unit for the multi-cycle CPU. It takes the
//   register file's rs1_dout/rs2_dout as op_a/op_b and produces a result plus
//   a one-cycle write strobe. Those outputs drive the register file's rd_din,
//   rd and write_enable inputs.
//   Uses a radix-2 shift-add multiplier and a restoring divider; one bit is
//   processed per cycle.
// PARAMETERS
//   XLEN    32   operand/result width; iteration count = XLEN
// PORTS
//   clk        in   1     clock; all state updates on posedge
//   reset      in   1     synchronous, active-high reset
//   start      in   1     request; sampled only while busy==0
//   funct3     in   3     0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   op_a       in   XLEN  rs1 value (multiplicand / dividend)
//   op_b       in   XLEN  rs2 value (multiplier / divisor)
//   rd_in      in   5     destination tag, captured with start
//   busy       out  1     high from the edge that accepts start until the edge done rises
//   done       out  1     single-cycle pulse; result and rd_out are valid in this cycle
//   result     out  XLEN  final value; held until the next accepted start
//   rd_out     out  5     captured rd_in; held like result
// BEHAVIOUR
//   Reset values: busy=0, done=0, result=0, rd_out=0, state=IDLE, iteration count=0.
//   Reset wins over start in the same cycle. Reset mid-operation aborts the
//   operation, drops to IDLE and raises no done.
//   FSM states and transitions:
//     IDLE -> CALC on start. Latch funct3, rd_in, |op_a|, |op_b| and the sign
//       flags; clear the accumulator; set busy=1.
//     IDLE -> DONE on start when the operation is a special case (see below).
//       done is then high in the cycle after the start edge.
//     CALC: runs exactly XLEN cycles, then -> DONE. done is high XLEN+1 cycles
//       after the start edge.
//     DONE: done=1 and busy=0 for one cycle, then -> IDLE. A start seen in
//       DONE is accepted as in IDLE (back-to-back operation).
//   start while busy: ignored. It is not queued and the latched operands do not change.
//   Signed handling:
//     Operate on magnitudes, then conditionally two's-complement negate the final value.
//     MUL/MULH: both operands signed. MULHSU: op_a signed, op_b unsigned.
//       MULHU/DIVU/REMU: both unsigned.
//     Product sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sa (follows the dividend).
//   Multiply:
//     2*XLEN-bit product. MUL returns product[XLEN-1:0].
//     MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
//   Divide: restoring algorithm on a 2*XLEN-bit {rem,quot} register. Each cycle:
//     shift left 1, subtract the divisor from the upper half.
//     If no borrow, keep the difference and set quot[0]=1.
//   Special cases (no CALC, one-cycle latency):
//     divisor == 0:
//       DIV/DIVU -> all ones
//       REM/REMU -> op_a
//     DIV/REM with op_a == 0x8000_0000 and op_b == all ones:
//       DIV -> 0x8000_0000
//       REM -> 0
//   Operands are latched at accept, so changes on op_a/op_b/funct3 during busy
//   have no effect.
//   result and rd_out update only on the edge that enters DONE.
//   done never asserts two cycles in a row for a single start.
// TESTING
//   MUL: 7 * 0xFFFF_FFFD -> result 0xFFFF_FFEB; done 33 cycles after start;
//     rd_out = rd_in.
//   MULH: 0x8000_0000^2 -> 0x4000_0000.
//   MULHU: 0xFFFF_FFFF^2 -> 0xFFFF_FFFE.
//   MULHSU: 0xFFFF_FFFF (-1) * 0xFFFF_FFFF -> 0xFFFF_FFFF.
//   DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF.
//   DIVU 100/7 -> 14; REMU 100/7 -> 2.
//   DIVU 5/0 -> 0xFFFF_FFFF and REMU 5/0 -> 5; DIV 0x8000_0000 / -1 -> 0x8000_0000.
//     Each asserts done 1 cycle after start.
//   Pulse start at cycle 10 of an active MUL with different operands:
//     ignored; the first result is unchanged.
//   Start a back-to-back op in the DONE cycle: accepted; the second done
//     arrives 33 cycles later.
//   Assert reset at CALC cycle 16: busy=0, done stays 0, result=0.
//     A new op after reset completes correctly.

Source files
------------

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit
// Radix-2 shift-add multiplier and restoring divider, one bit per cycle.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              sa_q, sb_q;
  logic [XLEN-1:0]   mag_q;
  logic [2*XLEN-1:0] acc, acc_next;

  logic              accept, last;
  logic              a_signed, b_signed, sa_in, sb_in;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_val;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_up, div_diff;
  logic [2*XLEN-1:0] div_next;

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mul_res, quot_s, rem_s, div_res, calc_res;

  assign accept = start && (state != S_CALC);
  assign last   = (cnt == CW'(XLEN - 1));

  // Operand decode at accept: signedness, magnitudes and the no-iteration cases.
  always_comb begin
    a_signed    = funct3[2] ? ~funct3[0] : (funct3 != 3'd3);
    b_signed    = funct3[2] ? ~funct3[0] : ~funct3[1];
    sa_in       = a_signed & op_a[XLEN-1];
    sb_in       = b_signed & op_b[XLEN-1];
    abs_a       = sa_in ? (-op_a) : op_a;
    abs_b       = sb_in ? (-op_b) : op_b;
    div_zero    = funct3[2] && (op_b == '0);
    div_ovf     = funct3[2] && ~funct3[0] &&
                  (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special     = div_zero | div_ovf;
    special_val = '0;
    if (div_zero)
      special_val = funct3[1] ? op_a : '1;
    else if (div_ovf)
      special_val = funct3[1] ? '0 : op_a;
  end

  // One iteration step; mag_q holds |a| for multiply and |b| for divide.
  always_comb begin
    mul_sum  = acc[0] ? ({1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mag_q})
                      : {1'b0, acc[2*XLEN-1:XLEN]};
    mul_next = {mul_sum, acc[XLEN-1:1]};

    // Upper half after the shift needs XLEN+1 bits since rem < divisor only.
    div_up   = acc[2*XLEN-1:XLEN-1];
    div_diff = div_up - {1'b0, mag_q};
    if (div_diff[XLEN])
      div_next = {div_up[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    acc_next = op_q[2] ? div_next : mul_next;
  end

  // Sign fix-up applied to the value produced by the final iteration.
  always_comb begin
    prod_s   = (sa_q ^ sb_q) ? (-acc_next) : acc_next;
    mul_res  = (op_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    quot_s   = (sa_q ^ sb_q) ? (-acc_next[XLEN-1:0]) : acc_next[XLEN-1:0];
    rem_s    = sa_q ? (-acc_next[2*XLEN-1:XLEN]) : acc_next[2*XLEN-1:XLEN];
    div_res  = op_q[1] ? rem_s : quot_s;
    calc_res = op_q[2] ? div_res : mul_res;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start)
          state_next = special ? S_DONE : S_CALC;
        else
          state_next = S_IDLE;
      end
      S_CALC: begin
        busy = 1'b1;
        if (last)
          state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      rd_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      mag_q  <= '0;
      acc    <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q  <= funct3;
        rd_q  <= rd_in;
        sa_q  <= sa_in;
        sb_q  <= sb_in;
        cnt   <= '0;
        mag_q <= funct3[2] ? abs_b : abs_a;
        acc   <= {{XLEN{1'b0}}, (funct3[2] ? abs_a : abs_b)};
        if (special) begin
          result <= special_val;
          rd_out <= rd_in;
        end
      end else if (state == S_CALC) begin
        acc <= acc_next;
        if (last) begin
          cnt    <= '0;
          result <= calc_res;
          rd_out <= rd_q;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      ea, eb;
    logic [63:0] p;
    logic        a_s, b_s;
    logic        ovf;
    a_s = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 6);
    b_s = (f3 == 0) || (f3 == 1) || (f3 == 4) || (f3 == 6);
    ea  = a_s ? longint'($signed(a)) : longint'({32'd0, a});
    eb  = b_s ? longint'($signed(b)) : longint'({32'd0, b});
    ovf = a_s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ea * eb; return p[31:0]; end
      3'd1, 3'd2, 3'd3: begin p = ea * eb; return p[63:32]; end
      3'd4, 3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = ea / eb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = ea % eb;
        return p[31:0];
      end
    endcase
  endfunction

  // Drives a request for one edge, then scrambles the inputs to prove they were latched.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = 3'($urandom);
    op_a   = $urandom;
    op_b   = $urandom;
    rd_in  = 5'($urandom);
  endtask

  // Counts negedges after the accepting edge until done; poke_at>0 injects a stray start.
  task automatic wait_done(input int poke_at, output int lat, output logic busy_first);
    lat = -1;
    busy_first = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) busy_first = busy;
      if (poke_at > 0 && c == poke_at + 1) start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
      if (c == poke_at) begin
        start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd9;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for done actual=none required=pulse");
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic b1;
    logic [4:0] rd;
    rd = 5'($urandom_range(1, 31));
    issue(f3, a, b, rd);
    wait_done(-1, lat, b1);
    check({name, "_result"}, result, exp);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_rd_out"}, 32'(rd_out), 32'(rd));
    check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    if (exp_lat > 1) check({name, "_busy_early"}, 32'(b1), 32'd1);
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  function automatic logic [31:0] pick(input logic allow_zero);
    case ($urandom_range(0, 7))
      0: return allow_zero ? 32'd0 : 32'd1;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[14];

  initial begin
    int   lat, lat2;
    logic b1;
    logic saw_done;
    logic [2:0]  f3;
    logic [31:0] a, b;

    vecs[0]  = '{"mul",       3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{"mulh",      3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{"mulhu",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{"mulhsu",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{"div_neg",   3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{"rem_neg",   3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{"divu",      3'd5, 32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{"remu",      3'd7, 32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{"divu_zero", 3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{"remu_zero", 3'd7, 32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{"div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{"rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[12] = '{"div_zero",  3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 1};
    vecs[13] = '{"rem_zero",  3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1};

    reset = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    // start held high during reset must not launch anything
    start = 1'b1; funct3 = 3'd5; op_a = 32'd9; op_b = 32'd0; rd_in = 5'd3;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd_out", 32'(rd_out), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Stray start during an active multiply is neither taken nor queued.
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd4);
    wait_done(10, lat, b1);
    check("ignore_result", result, 32'hFFFF_FFEB);
    check("ignore_latency", 32'(lat), 32'd33);
    check("ignore_rd_out", 32'(rd_out), 32'd4);
    @(negedge clk);
    check("ignore_not_queued_busy", 32'(busy), 32'd0);
    check("ignore_not_queued_done", 32'(done), 32'd0);

    // Back-to-back: second request issued in the done cycle.
    issue(3'd5, 32'd100, 32'd7, 5'd11);
    wait_done(-1, lat, b1);
    check("b2b_first_result", result, 32'd14);
    issue(3'd7, 32'd100, 32'd7, 5'd12);
    wait_done(-1, lat2, b1);
    check("b2b_second_latency", 32'(lat2), 32'd33);
    check("b2b_second_result", result, 32'd2);
    check("b2b_second_rd_out", 32'(rd_out), 32'd12);
    @(negedge clk);

    // Reset partway through CALC aborts silently.
    issue(3'd0, 32'd12345, 32'd678, 5'd7);
    repeat (16) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    run_op("after_abort", 3'd5, 32'd100, 32'd7, 32'd14, 33);

    for (int i = 0; i < 200; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick(1'b1);
      b  = pick(1'b1);
      run_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, ref_model(f3, a, b),
             is_special(f3, a, b) ? 1 : 33);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
